// File: rtl/fft_ctrl_pkg.sv
// Shared constants and the frame-controller state type.
package fft_ctrl_pkg;

  localparam int N_POINTS = 8;
  localparam int IDX_W    = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Sample-in / bin-out stream bundle of the FFT frame controller.
// The controller uses the slave view; the sample source / result sink uses master.
interface fft_frame_ctrl_if #(
  parameter int WIDTH = 9
) ();
  import fft_ctrl_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_re;
  logic [WIDTH-1:0] m_im;
  logic [IDX_W-1:0] m_idx;
  logic             m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_re, m_im, m_idx, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_re, m_im, m_idx, m_last
  );

endinterface

// File: rtl/fft_out_serializer.sv
// Result buffer for one 8-point FFT frame and the bin multiplexer that walks it.
module fft_out_serializer
  import fft_ctrl_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        capture,
  input  logic [2*N_POINTS*WIDTH-1:0] y,
  input  logic                        advance,
  output logic [WIDTH-1:0]            re,
  output logic [WIDTH-1:0]            im,
  output logic [IDX_W-1:0]            idx
);

  logic [2*N_POINTS*WIDTH-1:0] res_q;
  logic [IDX_W-1:0]            j;

  // Capture all 16 words at once; the bin pointer restarts at 0 on capture and
  // wraps 7->0 on the last handshake so the next frame starts at bin 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q <= '0;
      j     <= '0;
    end else if (capture) begin
      res_q <= y;
      j     <= '0;
    end else if (advance) begin
      j <= j + 1'b1;
    end
  end

  assign re  = res_q[(2 * int'(j)) * WIDTH +: WIDTH];
  assign im  = res_q[(2 * int'(j) + 1) * WIDTH +: WIDTH];
  assign idx = j;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller around an 8-point FFT core: gathers 8 samples, launches the
// core with a one-cycle active-low strobe, waits (bounded) for its result and
// streams the 8 complex bins out.
//
//   state | meaning
//   IDLE  | waiting for first sample of a frame (slot 0)
//   LOAD  | collecting samples into slots 1..7
//   START | one-cycle launch strobe, fft_rstn_o = 0
//   WAIT  | waiting for fft_vld, bounded by TIMEOUT
//   DRAIN | presenting bins 0..7 on the output stream
module fft_frame_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int WIDTH   = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        rstn,
  fft_frame_ctrl_if.slave             bus,
  output logic                        fft_rstn_o,
  output logic [N_POINTS*WIDTH-1:0]   fft_x,
  input  logic [2*N_POINTS*WIDTH-1:0] fft_y,
  input  logic                        fft_vld,
  output logic                        err_timeout,
  output logic [7:0]                  frame_cnt
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Last WAIT count before giving up: the error pulse then lands exactly
  // TIMEOUT cycles after the START cycle.
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(TIMEOUT - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  state_t           state;
  logic [IDX_W-1:0] k;
  logic [CNT_W-1:0] wait_cnt;

  logic             in_ready;
  logic             accept;
  logic             capture;
  logic             advance;
  logic             m_valid;
  logic [IDX_W-1:0] m_idx;
  logic [WIDTH-1:0] m_re;
  logic [WIDTH-1:0] m_im;

  // Gated by rstn so s_ready is low during reset and high from the first
  // cycle after release.
  assign in_ready = rstn && ((state == IDLE) || (state == LOAD));
  assign accept   = bus.s_valid && in_ready;
  assign capture  = (state == WAIT) && fft_vld;
  assign m_valid  = (state == DRAIN);
  assign advance  = m_valid && bus.m_ready;

  assign bus.s_ready = in_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_re    = m_re;
  assign bus.m_im    = m_im;
  assign bus.m_idx   = m_idx;
  assign bus.m_last  = m_valid && (m_idx == LAST_IDX);

  fft_out_serializer #(
    .WIDTH (WIDTH)
  ) u_ser (
    .clk     (clk),
    .rstn    (rstn),
    .capture (capture),
    .y       (fft_y),
    .advance (advance),
    .re      (m_re),
    .im      (m_im),
    .idx     (m_idx)
  );

  // Frame sequencing, sample loading, launch strobe, timeout and frame count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      k           <= '0;
      wait_cnt    <= '0;
      fft_x       <= '0;
      fft_rstn_o  <= 1'b1;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      fft_rstn_o  <= 1'b1;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            fft_x[0 +: WIDTH] <= bus.s_data;
            k                 <= IDX_W'(1);
            state             <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            fft_x[int'(k) * WIDTH +: WIDTH] <= bus.s_data;
            if (k == LAST_IDX) begin
              k          <= '0;
              fft_rstn_o <= 1'b0;
              state      <= START;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (fft_vld) begin
            state <= DRAIN;
          end else if (wait_cnt == WAIT_END) begin
            err_timeout <= 1'b1;
            k           <= '0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (advance && (m_idx == LAST_IDX)) begin
            frame_cnt <= frame_cnt + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed + randomized bench for fft_frame_ctrl with an inline core stub and
// a frame-level reference model (sample array in, bin array out).
module tb_fft_frame_ctrl;
  import fft_ctrl_pkg::*;

  localparam int W  = 9;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            rstn;
  logic            fft_rstn_o;
  logic [8*W-1:0]  fft_x;
  logic [16*W-1:0] fft_y;
  logic            fft_vld;
  logic            err_timeout;
  logic [7:0]      frame_cnt;

  fft_frame_ctrl_if #(.WIDTH(W)) bus ();

  fft_frame_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .fft_rstn_o  (fft_rstn_o),
    .fft_x       (fft_x),
    .fft_y       (fft_y),
    .fft_vld     (fft_vld),
    .err_timeout (err_timeout),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   samp [8];
  logic [W-1:0]   yr   [8];
  logic [W-1:0]   yi   [8];
  logic [8*W-1:0] exp_x;
  logic [7:0]     exp_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16*W-1:0] pack_y();
    logic [16*W-1:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      v[(2*b)*W +: W]   = yr[b];
      v[(2*b+1)*W +: W] = yi[b];
    end
    return v;
  endfunction

  task automatic junk_core(input bit noise);
    fft_y   = 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
    fft_vld = noise ? 1'($urandom) : 1'b0;
  endtask

  task automatic rand_frame_data();
    for (int i = 0; i < 8; i++) begin
      samp[i] = W'($urandom);
      yr[i]   = W'($urandom);
      yi[i]   = W'($urandom);
    end
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    fft_vld     = 1'b0;
    #1;
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_fft_rstn", fft_rstn_o, 1);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last", bus.m_last, 0);
    chk("rst_m_idx", bus.m_idx, 0);
    chk("rst_m_re", bus.m_re, 0);
    chk("rst_m_im", bus.m_im, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_fft_x", fft_x, 0);
    step();
    chk("rst_hold_s_ready", bus.s_ready, 0);
    #2 rstn = 1'b1;
    #1;
    chk("rel_s_ready", bus.s_ready, 1);
    chk("rel_err", err_timeout, 0);
    exp_cnt = 8'd0;
  endtask

  // lat = cycles from START to fft_vld (1..TO-1); lat = 0 means core never answers.
  // rmode: 0 = m_ready always 1, 1 = 1,0,0,1 then 1, 2 = random.
  task automatic run_frame(input int lat, input int rmode, input bit gaps, input bit noise);
    int j;
    int cyc;
    bit r;
    for (int i = 0; i < 8; i++) exp_x[i*W +: W] = samp[i];
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.s_valid = 1'b0;
          junk_core(noise);
          chk("gap_s_ready", bus.s_ready, 1);
          chk("gap_m_valid", bus.m_valid, 0);
          step();
        end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = samp[i];
      junk_core(noise);
      chk("load_s_ready", bus.s_ready, 1);
      chk("load_fft_rstn", fft_rstn_o, 1);
      step();
    end
    // START cycle: a sample offered here must not be taken
    bus.s_valid = 1'b1;
    bus.s_data  = W'($urandom);
    junk_core(noise);
    chk("start_fft_rstn", fft_rstn_o, 0);
    chk("start_s_ready", bus.s_ready, 0);
    chk("start_fft_x", fft_x, exp_x);
    step();
    if (lat == 0) begin
      for (int d = 1; d <= TO; d++) begin
        junk_core(1'b0);
        chk("to_err", err_timeout, (d == TO));
        if (d == TO) begin
          bus.s_valid = 1'b0;
          chk("to_s_ready_idle", bus.s_ready, 1);
          chk("to_frame_cnt", frame_cnt, exp_cnt);
        end else begin
          chk("to_s_ready_wait", bus.s_ready, 0);
          chk("to_fft_rstn", fft_rstn_o, 1);
        end
        step();
      end
      chk("to_err_after", err_timeout, 0);
      chk("to_s_ready_after", bus.s_ready, 1);
      return;
    end
    for (int d = 1; d <= lat; d++) begin
      junk_core(1'b0);
      if (d == lat) begin
        fft_vld = 1'b1;
        fft_y   = pack_y();
      end
      chk("wait_s_ready", bus.s_ready, 0);
      chk("wait_fft_rstn", fft_rstn_o, 1);
      chk("wait_m_valid", bus.m_valid, 0);
      chk("wait_err", err_timeout, 0);
      step();
    end
    j   = 0;
    cyc = 0;
    while (j < 8) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        default: r = (cyc >= 16) ? 1'b1 : 1'($urandom);
      endcase
      bus.m_ready = r;
      junk_core(noise);
      chk("drain_m_valid", bus.m_valid, 1);
      chk("drain_m_idx", bus.m_idx, j);
      chk("drain_m_re", bus.m_re, yr[j]);
      chk("drain_m_im", bus.m_im, yi[j]);
      chk("drain_m_last", bus.m_last, (j == 7));
      chk("drain_s_ready", bus.s_ready, 0);
      chk("drain_fft_x", fft_x, exp_x);
      if (r) j++;
      cyc++;
      step();
    end
    exp_cnt     = exp_cnt + 8'd1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    fft_vld     = 1'b0;
    chk("post_m_valid", bus.m_valid, 0);
    chk("post_m_last", bus.m_last, 0);
    chk("post_frame_cnt", frame_cnt, exp_cnt);
    chk("post_s_ready", bus.s_ready, 1);
    if (rmode == 0) chk("drain_cycles", cyc, 8);
  endtask

  initial begin
    rstn        = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    fft_vld     = 1'b0;
    fft_y       = '0;
    exp_cnt     = 8'd0;
    #1;
    do_reset();

    // Powers of two, core answers 3 cycles after launch with y_kr=k, y_ki=-k.
    for (int i = 0; i < 8; i++) begin
      samp[i] = W'(1 << i);
      yr[i]   = W'(i);
      yi[i]   = W'(-i);
    end
    run_frame(3, 0, 1'b0, 1'b0);
    chk("pow2_fft_x", fft_x, {9'd128, 9'd64, 9'd32, 9'd16, 9'd8, 9'd4, 9'd2, 9'd1});

    // Backpressure pattern during drain.
    rand_frame_data();
    run_frame(2, 1, 1'b0, 1'b0);

    // Core never answers.
    rand_frame_data();
    run_frame(0, 0, 1'b0, 1'b0);

    // Latest legal answer, then earliest.
    rand_frame_data();
    run_frame(TO - 1, 0, 1'b0, 1'b1);
    rand_frame_data();
    run_frame(1, 2, 1'b1, 1'b1);

    // Randomized frames with gaps, backpressure and spurious fft_vld outside WAIT.
    for (int f = 0; f < 12; f++) begin
      rand_frame_data();
      run_frame((f % 5 == 4) ? 0 : $urandom_range(1, TO - 1), 2, 1'b1, 1'b1);
    end

    // Reset in the middle of loading.
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = W'($urandom);
      step();
    end
    do_reset();
    rand_frame_data();
    run_frame($urandom_range(1, TO - 1), 0, 1'b0, 1'b0);

    // 256 back-to-back frames from a clean reset: counter wraps to 0.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      rand_frame_data();
      run_frame($urandom_range(1, 4), 0, 1'b0, 1'($urandom));
    end
    chk("wrap_frame_cnt", frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
